// File: rtl/demux16_stream_router_if.sv
// Stream bundle for the 1-to-2 operand router: one input stream, two output
// streams and the per-channel delivered-word counters.
interface demux16_stream_router_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outa_data;
    logic             outa_valid;
    logic             outa_ready;
    logic [WIDTH-1:0] outb_data;
    logic             outb_valid;
    logic             outb_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output in_data, in_sel, in_valid, outa_ready, outb_ready,
        input  in_ready, outa_data, outa_valid, outb_data, outb_valid, cnt_a, cnt_b
    );

    modport slave (
        input  in_data, in_sel, in_valid, outa_ready, outb_ready,
        output in_ready, outa_data, outa_valid, outb_data, outb_valid, cnt_a, cnt_b
    );
endinterface

// File: rtl/demux16_stream_router.sv
// Steers each input word by its select bit into one of two per-channel FIFOs
// (0 = A, 1 = B) and counts the words each consumer takes.
module demux16_stream_router #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    demux16_stream_router_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    logic [WIDTH-1:0] r_mem  [2][DEPTH];
    logic [PtrW-1:0]  r_wptr [2];
    logic [PtrW-1:0]  r_rptr [2];
    logic [OccW-1:0]  r_occ  [2];
    logic [CNT_W-1:0] r_cnt  [2];

    logic w_full      [2];
    logic w_empty     [2];
    logic w_push      [2];
    logic w_pop       [2];
    logic w_out_ready [2];
    logic w_in_ready;
    logic w_accept;

    // Readiness looks only at the selected channel's registered occupancy, so a
    // full channel stalls the input even when it pops this cycle.
    always_comb begin
        w_out_ready[0] = bus.outa_ready;
        w_out_ready[1] = bus.outb_ready;
        for (int c = 0; c < 2; c++) begin
            w_full[c]  = (r_occ[c] == OccW'(DEPTH));
            w_empty[c] = (r_occ[c] == '0);
            w_pop[c]   = !w_empty[c] && w_out_ready[c];
        end
        w_in_ready = bus.in_sel ? !w_full[1] : !w_full[0];
        w_accept   = bus.in_valid && w_in_ready;
        w_push[0]  = w_accept && !bus.in_sel;
        w_push[1]  = w_accept && bus.in_sel;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.outa_valid = !w_empty[0];
    assign bus.outb_valid = !w_empty[1];
    assign bus.outa_data  = w_empty[0] ? '0 : r_mem[0][r_rptr[0]];
    assign bus.outb_data  = w_empty[1] ? '0 : r_mem[1][r_rptr[1]];
    assign bus.cnt_a      = r_cnt[0];
    assign bus.cnt_b      = r_cnt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_occ[c]  <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_push[c]) begin
                    r_wptr[c] <= r_wptr[c] + PtrW'(1);
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + PtrW'(1);
                    r_cnt[c]  <= r_cnt[c] + CNT_W'(1);
                end
                if (w_push[c] && !w_pop[c]) begin
                    r_occ[c] <= r_occ[c] + OccW'(1);
                end else if (w_pop[c] && !w_push[c]) begin
                    r_occ[c] <= r_occ[c] - OccW'(1);
                end
            end
        end
    end

    // Storage needs no reset: empty channels mask their data output to zero.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst_n && w_push[c]) begin
                r_mem[c][r_wptr[c]] <= bus.in_data;
            end
        end
    end
endmodule
